// File: rtl/lsu_pkg.sv
// lsu_pkg: op codes, FSM states and timeout counter sizing for mem_lsu
package lsu_pkg;
  localparam logic [4:0] OP_LW = 5'b10100;
  localparam logic [4:0] OP_SW = 5'b10101;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  function automatic int cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/lsu_timeout_cnt.sv
// lsu_timeout_cnt: counts waiting cycles and flags expiry on the cycle the count reaches TIMEOUT
module lsu_timeout_cnt
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int W = cnt_w(TIMEOUT);
  logic [W-1:0] cnt;
  // expiry is seen combinationally so the FSM can leave REQ on the TIMEOUT-th waiting cycle
  assign expired = (TIMEOUT != 0) && enable && (cnt == W'(TIMEOUT - 1));
  // waiting-cycle counter, restarted whenever a new access is launched
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: word load/store unit with req/ack data-memory bus, core stall and timeout; LSU_MISALIGN_TRAP_EN adds a misalign trap
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        alu_op,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              ld_valid,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);
  state_t state, state_n;
  logic mem_op, mis, start, fin, expired;
  assign mem_op = (alu_op == OP_LW) || (alu_op == OP_SW);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = mem_op && (alu_out[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign start = (state == IDLE) && mem_op && !mis;
  assign fin   = (state == REQ) && (dmem_ack || expired);
  assign stall = !rst && (((state == IDLE) && mem_op) || (state == REQ));
  lsu_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .enable (state == REQ),
    .clear  (start),
    .expired(expired)
  );
  // next state: DONE always falls back to IDLE so an instruction is never reissued
  always_comb begin
    state_n = (state == IDLE) ? (mem_op ? (mis ? DONE : REQ) : IDLE) :
              (state == REQ)  ? (fin ? DONE : REQ) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // registered bus outputs, load result and completion pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
      ld_valid   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      dmem_req <= (state_n == REQ);
      ld_valid <= fin && dmem_ack && !dmem_we;
      bus_err  <= fin && !dmem_ack;
      if (start) begin
        dmem_we    <= (alu_op == OP_SW);
        dmem_addr  <= alu_out[ADDR_W-1:0] & ~ADDR_W'(3);
        dmem_wdata <= store_data;
      end
      if (fin) load_data <= dmem_ack ? (dmem_we ? load_data : dmem_rdata) : 32'd0;
    end
`ifdef LSU_MISALIGN_TRAP_EN
  // misaligned access never reaches the bus; it is reported while in DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) misalign <= 1'b0;
    else misalign <= (state == IDLE) && mis;
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu (TIMEOUT=4)
module tb_mem_lsu;
  import lsu_pkg::*;
  localparam logic [4:0] OP_ADD = 5'b01101;
  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  alu_op = 5'b01101;
  logic [31:0] alu_out = '0, store_data = '0, dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        stall, ld_valid, bus_err, dmem_req, dmem_we;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .alu_out(alu_out), .store_data(store_data),
    .stall(stall), .load_data(load_data), .ld_valid(ld_valid), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  task automatic test_reset;
    @(negedge clk);
    total++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, load_data, ld_valid, bus_err, stall} !== '0) begin bad++; $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h ld=%h v=%b err=%b st=%b want all 0", dmem_req, dmem_we, dmem_addr, dmem_wdata, load_data, ld_valid, bus_err, stall); end
    rst = 1'b0;
  endtask

  task automatic test_lw;
    @(negedge clk); alu_op = OP_LW; alu_out = 32'h10; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall_idle got=%b want=1", stall); end
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL lw_req_idle got=%b want=0", dmem_req); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({dmem_req, dmem_we, stall} !== 3'b101) begin bad++; $display("FAIL lw_req_cycle%0d got req/we/stall=%b want=101", i, {dmem_req, dmem_we, stall}); end
      total++; if (dmem_addr !== 32'h10) begin bad++; $display("FAIL lw_addr got=%h want=00000010", dmem_addr); end
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
    end
    @(negedge clk);
    total++; if ({dmem_req, ld_valid, stall} !== 3'b010) begin bad++; $display("FAIL lw_done got req/v/stall=%b want=010", {dmem_req, ld_valid, stall}); end
    total++; if (load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", load_data); end
    dmem_ack = 1'b0; alu_op = OP_ADD;
    @(negedge clk);
    total++; if ({dmem_req, ld_valid} !== 2'b00) begin bad++; $display("FAIL lw_after got req/v=%b want=00", {dmem_req, ld_valid}); end
  endtask

  task automatic test_sw;
    @(negedge clk); alu_op = OP_SW; alu_out = 32'h24; store_data = 32'h12345678; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sw_stall_idle got=%b want=1", stall); end
    @(negedge clk);
    total++; if ({dmem_req, dmem_we, stall} !== 3'b111) begin bad++; $display("FAIL sw_req got req/we/stall=%b want=111", {dmem_req, dmem_we, stall}); end
    total++; if (dmem_wdata !== 32'h12345678) begin bad++; $display("FAIL sw_wdata got=%h want=12345678", dmem_wdata); end
    total++; if (dmem_addr !== 32'h24) begin bad++; $display("FAIL sw_addr got=%h want=00000024", dmem_addr); end
    dmem_ack = 1'b1;
    @(negedge clk);
    total++; if ({dmem_req, ld_valid, stall} !== 3'b000) begin bad++; $display("FAIL sw_done got req/v/stall=%b want=000", {dmem_req, ld_valid, stall}); end
    total++; if (load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_keeps_load got=%h want=deadbeef", load_data); end
    dmem_ack = 1'b0; alu_op = OP_ADD;
  endtask

  task automatic test_nonmem;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); alu_op = OP_ADD; dmem_ack = i[0]; #1;
      total++; if ({stall, dmem_req, ld_valid} !== 3'b000) begin bad++; $display("FAIL nonmem_cycle%0d got st/req/v=%b want=000", i, {stall, dmem_req, ld_valid}); end
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_timeout;
    @(negedge clk); alu_op = OP_LW; alu_out = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({dmem_req, stall} !== 2'b11) begin bad++; $display("FAIL tmo_req_cycle%0d got req/st=%b want=11", i, {dmem_req, stall}); end
    end
    @(negedge clk);
    total++; if ({dmem_req, bus_err, ld_valid, stall} !== 4'b0100) begin bad++; $display("FAIL tmo_done got req/err/v/st=%b want=0100", {dmem_req, bus_err, ld_valid, stall}); end
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL tmo_data got=%h want=00000000", load_data); end
    alu_op = OP_ADD;
    @(negedge clk);
    total++; if ({bus_err, dmem_req} !== 2'b00) begin bad++; $display("FAIL tmo_after got err/req=%b want=00", {bus_err, dmem_req}); end
    alu_op = OP_LW;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL tmo_race_req%0d got=%b want=1", i, dmem_req); end
      if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D; end
    end
    @(negedge clk);
    total++; if ({ld_valid, bus_err} !== 2'b10) begin bad++; $display("FAIL tmo_race_done got v/err=%b want=10", {ld_valid, bus_err}); end
    total++; if (load_data !== 32'hCAFEF00D) begin bad++; $display("FAIL tmo_race_data got=%h want=cafef00d", load_data); end
    dmem_ack = 1'b0; alu_op = OP_ADD;
  endtask

  task automatic test_misalign;
    @(negedge clk); alu_op = OP_LW; alu_out = 32'h13; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_stall_idle got=%b want=1", stall); end
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    total++; if ({misalign, dmem_req, ld_valid, stall} !== 4'b1000) begin bad++; $display("FAIL mis_trap got mis/req/v/st=%b want=1000", {misalign, dmem_req, ld_valid, stall}); end
    alu_op = OP_ADD;
    @(negedge clk);
    total++; if ({misalign, dmem_req} !== 2'b00) begin bad++; $display("FAIL mis_after got mis/req=%b want=00", {misalign, dmem_req}); end
`else
    @(negedge clk);
    total++; if ({dmem_req, dmem_we} !== 2'b10) begin bad++; $display("FAIL mis_req got req/we=%b want=10", {dmem_req, dmem_we}); end
    total++; if (dmem_addr !== 32'h10) begin bad++; $display("FAIL mis_addr got=%h want=00000010", dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    total++; if ({ld_valid, dmem_req} !== 2'b10) begin bad++; $display("FAIL mis_done got v/req=%b want=10", {ld_valid, dmem_req}); end
    total++; if (load_data !== 32'h0BADF00D) begin bad++; $display("FAIL mis_data got=%h want=0badf00d", load_data); end
    dmem_ack = 1'b0; alu_op = OP_ADD;
`endif
  endtask

  task automatic test_rst_mid;
    @(negedge clk); alu_op = OP_LW; alu_out = 32'h80;
    @(negedge clk);
    @(negedge clk);
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_before got=%b want=1", dmem_req); end
    #2 rst = 1'b1; #1;
    total++; if ({dmem_req, stall, ld_valid, bus_err, dmem_we} !== 5'b0) begin bad++; $display("FAIL rstmid_async got req/st/v/err/we=%b want=00000", {dmem_req, stall, ld_valid, bus_err, dmem_we}); end
    total++; if ({dmem_addr, load_data} !== 64'h0) begin bad++; $display("FAIL rstmid_regs got addr=%h ld=%h want 0", dmem_addr, load_data); end
    alu_op = OP_ADD;
    @(negedge clk); rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    total++; if ({ld_valid, dmem_req, stall, bus_err} !== 4'b0) begin bad++; $display("FAIL rstmid_late_ack got v/req/st/err=%b want=0000", {ld_valid, dmem_req, stall, bus_err}); end
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h want=00000000", load_data); end
    dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_nonmem();
    test_timeout();
    test_misalign();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
